// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port word memory: queues stores,
// drains them when the port is idle, and forwards the youngest pending store to loads.
module store_buffer #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Aw    = 32,
  parameter int unsigned Dw    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          store_m_i,
  input  logic          load_m_i,
  input  logic [Aw-1:0] addr_m_i,
  input  logic [Dw-1:0] wdata_m_i,
  output logic [Dw-1:0] rdata_m_o,
  output logic          stall_m_o,
  output logic          empty_m_o,
  output logic [Aw-1:0] mem_a_o,
  output logic [Dw-1:0] mem_wd_o,
  output logic          mem_we_o,
  input  logic [Dw-1:0] mem_rd_i
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Aw-1:0]   addr_q [Depth];
  logic [Dw-1:0]   data_q [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  logic            full, load_req, hit, port_load, push, pop;
  logic [Dw-1:0]   hit_data;
  logic [PtrW-1:0] idx;

  assign full      = (count_q == (PtrW+1)'(Depth));
  assign empty_m_o = (count_q == '0);
  // A simultaneous store and load is handled as a store alone.
  assign load_req  = load_m_i & ~store_m_i;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = head_q + PtrW'(k);
      if (((PtrW+1)'(k) < count_q) && (addr_q[idx] == addr_m_i)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_comb begin
    port_load = load_req & ~hit & ~full;
    pop       = ~port_load & ~empty_m_o;
    push      = store_m_i & ~full;
    stall_m_o = full & (store_m_i | (load_req & ~hit));

    mem_we_o  = pop;
    mem_wd_o  = data_q[head_q];
    if (port_load) begin
      mem_a_o = addr_m_i;
    end else if (!empty_m_o) begin
      mem_a_o = addr_q[head_q];
    end else begin
      mem_a_o = '0;
    end

    if (load_req && hit) begin
      rdata_m_o = hit_data;
    end else if (port_load) begin
      rdata_m_o = mem_rd_i;
    end else begin
      rdata_m_o = '0;
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PtrW'(1) : head_q;
    tail_d  = push ? tail_q + PtrW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= addr_m_i;
        data_q[tail_q] <= wdata_m_i;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model with a word memory, scoreboard
// of per-cycle expectations checked by an independent negedge monitor.
module tb_store_buffer;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        store_i = 1'b0, load_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic        stall, empty, mem_we;

  store_buffer #(.Depth(Depth), .Aw(32), .Dw(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .store_m_i(store_i),
    .load_m_i (load_i),
    .addr_m_i (addr_i),
    .wdata_m_i(wdata_i),
    .rdata_m_o(rdata),
    .stall_m_o(stall),
    .empty_m_o(empty),
    .mem_a_o  (mem_a),
    .mem_wd_o (mem_wd),
    .mem_we_o (mem_we),
    .mem_rd_i (mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, empty, we, chk_a, chk_rd;
    logic [31:0] a, wd, rd;
  } exp_t;

  typedef struct {
    logic [31:0] a, d;
  } ent_t;

  logic [31:0] mem [4096];
  logic [31:0] model_mem [4096];
  ent_t        pend [$];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  assign mem_rd = mem[mem_a[11:0]];

  // Memory: initial contents, then writes on posedge with pre-edge port values.
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]       = 32'h5000_0000 + i * 3;
      model_mem[i] = 32'h5000_0000 + i * 3;
    end
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a[11:0]] = mem_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle, predict the DUT response from the model, then advance the model.
  task automatic cycle(input logic st, input logic ld, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    logic full, hit, ld_only, port_ld;
    logic [31:0] hd;
    @(posedge clk);
    #1;
    store_i = st; load_i = ld; addr_i = a; wdata_i = d;
    full    = (pend.size() == Depth);
    ld_only = ld && !st;
    hit     = 1'b0;
    hd      = '0;
    foreach (pend[i]) if (pend[i].a == a) begin hit = 1'b1; hd = pend[i].d; end
    port_ld  = ld_only && !hit && !full;
    e.empty  = (pend.size() == 0);
    e.stall  = full && (st || (ld_only && !hit));
    e.we     = !port_ld && pend.size() > 0;
    e.chk_a  = port_ld || e.we;
    e.a      = port_ld ? a : (pend.size() > 0 ? pend[0].a : '0);
    e.wd     = pend.size() > 0 ? pend[0].d : '0;
    e.chk_rd = ld_only && !e.stall;
    e.rd     = hit ? hd : model_mem[a[11:0]];
    exp_q.push_back(e);
    if (e.we) begin
      model_mem[pend[0].a[11:0]] = pend[0].d;
      void'(pend.pop_front());
    end
    if (st && !full) pend.push_back('{a: a, d: d});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("empty", {31'b0, empty}, {31'b0, mon_e.empty});
      chk("stall", {31'b0, stall}, {31'b0, mon_e.stall});
      chk("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
      if (mon_e.chk_a) chk("mem_a", mem_a, mon_e.a);
      if (mon_e.we) chk("mem_wd", mem_wd, mon_e.wd);
      if (mon_e.chk_rd) chk("rdata", rdata, mon_e.rd);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Store then same-address load forwarded while it drains
    cycle(1'b1, 1'b0, 32'h400, 32'hAAAA);
    cycle(1'b0, 1'b1, 32'h400, '0);
    idle(2);

    // Duplicate addresses: youngest wins for forwarding and in memory
    cycle(1'b1, 1'b0, 32'h401, 32'd1);
    cycle(1'b1, 1'b0, 32'h402, 32'd2);
    cycle(1'b1, 1'b0, 32'h401, 32'd3);
    cycle(1'b0, 1'b1, 32'h401, '0);
    idle(3);
    cycle(1'b0, 1'b1, 32'h401, '0);

    // Stores interleaved with back-to-back load misses, then a further store
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h408 + i, 32'h100 + i);
      cycle(1'b0, 1'b1, 32'h7FFFFC, '0);
      cycle(1'b0, 1'b1, 32'h40F, '0);
    end
    cycle(1'b1, 1'b0, 32'h40C, 32'h104);
    cycle(1'b1, 1'b0, 32'h40D, 32'h105);
    cycle(1'b0, 1'b1, 32'h7FFFFC, '0);
    cycle(1'b0, 1'b1, 32'h7FFFFC, '0);

    // Wrap: ten distinct stores with idle gaps
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h410 + i, 32'hC0DE_0000 + i);
      if (i % 3 == 0) idle(1);
    end
    idle(3);
    // Store and load together act as a store
    cycle(1'b1, 1'b1, 32'h41A, 32'hBEEF);
    cycle(1'b0, 1'b1, 32'h41A, '0);

    // Randomized traffic over a small address window to force hits and duplicates
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 9);
      cycle(op <= 3 || op == 8, op >= 4 && op <= 8, 32'h400 + $urandom_range(0, 7),
            $urandom);
    end

    // Asynchronous reset with a store pending
    cycle(1'b1, 1'b0, 32'h41B, 32'h1111);
    cycle(1'b1, 1'b0, 32'h41C, 32'h2222);
    @(posedge clk);
    #1;
    store_i = 1'b0; load_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", {31'b0, empty}, 32'd1);
    chk("arst_we", {31'b0, mem_we}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    pend.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b1, 32'h41C, '0);
    cycle(1'b0, 1'b1, 32'h41B, '0);

    // Drain everything, bounded
    for (int i = 0; i < 4 * Depth + 4 && pend.size() > 0; i++) idle(1);
    idle(2);
    @(negedge clk);
    #1;
    chk("drained_model", pend.size(), 32'd0);
    chk("final_empty", {31'b0, empty}, 32'd1);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    for (int i = 12'h400; i < 12'h420; i++) chk($sformatf("mem[%h]", i), mem[i], model_mem[i]);
    chk("mem[ffc]", mem[12'hFFC], model_mem[12'hFFC]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
